// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl_pkg
//  Brief    : Shared state encoding and defaults for the SRAM controller.
//  Revision : 1.0
// ============================================================================
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic        C_HALF_LO         = 1'b0;
    localparam logic        C_HALF_HI         = 1'b1;
    localparam int unsigned C_DEF_WAIT_CYCLES = 5;
    localparam logic [31:0] C_DEF_BASE_ADDR   = 32'd1024;

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_ctrl_wait_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : wait_cnt
//  Brief    : 4-bit wait-state counter with clear/enable and a terminal flag.
//  Revision : 1.0
// ============================================================================
module wait_cnt
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = C_DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [3:0] C_LAST_COUNT = 4'(WAIT_CYCLES - 1);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (clr) begin
            r_count <= 4'd0;
        end else if (en) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign last = (r_count == C_LAST_COUNT);

endmodule : wait_cnt
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl
//  Brief    : Sequences 32-bit MEM-stage loads/stores as two 16-bit SRAM halves.
//  Revision : 1.0
// ============================================================================
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = C_DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = C_DEF_BASE_ADDR,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_read_data;
    logic        r_is_write;

    logic        w_req;
    logic        w_accept;
    logic        w_active;
    logic        w_half;
    logic        w_cnt_last;
    logic        w_last;
    logic [31:0] w_offset;
    logic        w_unused;

    assign w_req    = wr_en | rd_en;
    assign w_active = (r_state == ST_LOW) || (r_state == ST_HIGH);
    assign w_half   = (r_state == ST_HIGH) ? C_HALF_HI : C_HALF_LO;
    assign w_last   = w_active & w_cnt_last;

    // Out-of-range addresses simply wrap: only the word bits that fit are kept.
    assign w_offset = r_addr - BASE_ADDR;
    assign w_unused = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

    wait_cnt #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_accept | w_last),
        .en   (w_active),
        .last (w_cnt_last)
    );

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = ~w_req;
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_LOW;
                end
            end
            ST_LOW:  if (w_last) w_state_next = ST_HIGH;
            ST_HIGH: if (w_last) w_state_next = ST_DONE;
            ST_DONE: begin
                ready        = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // we_n releases on the final wait cycle so address/data are held past the strobe.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = 16'h0000;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (w_active) begin
            sram_addr = {w_offset[SRAM_AW:2], w_half};
            if (r_is_write) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = w_half ? r_wdata[31:16] : r_wdata[15:0];
                sram_we_n   = w_cnt_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_is_write  <= 1'b0;
            r_read_data <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr     <= address;
                r_wdata    <= write_data;
                r_is_write <= wr_en;
            end
            if (w_last && !r_is_write) begin
                if (r_state == ST_LOW) begin
                    r_read_data[15:0] <= sram_dq_in;
                end else begin
                    r_read_data[31:16] <= sram_dq_in;
                end
            end
        end
    end

    assign read_data = r_read_data;

endmodule : sram_ctrl
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_ctrl
//  Brief    : Scoreboard bench for sram_ctrl with a behavioural SRAM model.
//  Revision : 1.0
// ============================================================================
module tb_sram_ctrl;

    localparam int C_WAIT    = 5;
    localparam int C_LATENCY = 2 * C_WAIT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in = 16'h0000;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        is_done;
        logic [17:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    logic [15:0] mem [int];

    sram_ctrl #(
        .WAIT_CYCLES (C_WAIT),
        .BASE_ADDR   (32'd1024),
        .SRAM_AW     (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: commit while we_n is low, present read data mid-cycle.
    always @(posedge clk) begin
        if (sram_we_n === 1'b0 && sram_dq_oe === 1'b1)
            mem[int'(sram_addr)] = sram_dq_out;
    end
    always @(negedge clk) begin
        sram_dq_in = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 16'h0000;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_expect(input logic want_done, output exp_t e, output bit ok);
        tests++;
        ok = 1'b0;
        e  = '0;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_order: unexpected %s event, queue empty", want_done ? "done" : "beat");
        end else begin
            e = sb.pop_front();
            if (e.is_done !== want_done) begin
                fails++;
                $display("FAIL sb_order: got %s event expected %s", want_done ? "done" : "beat",
                         e.is_done ? "done" : "beat");
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: a write beat is the start of a we_n pulse, completion is ready rising.
    int   cyc = 0;
    int   start_cyc = 0;
    int   lo_cnt = 0;
    logic prev_ready = 1'b1;
    logic prev_we_n = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        cyc++;
        if (rst) begin
            prev_ready = 1'b1;
            prev_we_n  = 1'b1;
            lo_cnt     = 0;
        end else begin
            if (prev_we_n === 1'b1 && sram_we_n === 1'b0) begin
                pop_expect(1'b0, e, ok);
                if (ok) begin
                    check("beat_addr", 32'(sram_addr), 32'(e.addr));
                    check("beat_data", 32'(sram_dq_out), e.data);
                    check("beat_oe", 32'(sram_dq_oe), 32'd1);
                end
                lo_cnt = 1;
            end else if (sram_we_n === 1'b0) begin
                lo_cnt++;
            end
            if (prev_we_n === 1'b0 && sram_we_n === 1'b1)
                check("we_n_low_cycles", lo_cnt, C_WAIT - 1);
            if (prev_ready === 1'b1 && ready === 1'b0)
                start_cyc = cyc;
            if (prev_ready === 1'b0 && ready === 1'b1) begin
                pop_expect(1'b1, e, ok);
                if (ok) begin
                    check("done_read_data", read_data, e.data);
                    check("done_latency", cyc - start_cyc, C_LATENCY);
                end
            end
            prev_ready = ready;
            prev_we_n  = sram_we_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One access; expected beats/result are hand-computed by the caller.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [17:0] exp_lo_addr,
                          input logic [31:0] exp_rd, input bit release_req,
                          input int scramble_at);
        bit done = 1'b0;
        if (wr) begin
            sb.push_back('{is_done: 1'b0, addr: exp_lo_addr, data: {16'h0, wdata[15:0]}});
            sb.push_back('{is_done: 1'b0, addr: exp_lo_addr + 18'd1, data: {16'h0, wdata[31:16]}});
        end
        sb.push_back('{is_done: 1'b1, addr: 18'd0, data: exp_rd});
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = wdata;
        for (int n = 1; n <= 40 && !done; n++) begin
            tick();
            if (n == scramble_at) begin
                address    = 32'd2000;
                write_data = 32'h0000_0000;
            end
            if (ready === 1'b1) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL access_timeout: addr %h never completed", addr);
        end
        if (release_req) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst = 1'b0;
        idle(2);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_we_n", 32'(sram_we_n), 32'd1);
        check("reset_oe", 32'(sram_dq_oe), 32'd0);
        check("reset_read_data", read_data, 32'd0);
        check("reset_sram_addr", 32'(sram_addr), 32'd0);

        // Store then load of 1032 -> word 2 -> halves 4/5.
        access(1, 0, 32'd1032, 32'hDEAD_BEEF, 18'd4, 32'h0000_0000, 1, 0);
        idle(2);
        access(0, 1, 32'd1032, 32'h0, 18'd0, 32'hDEAD_BEEF, 1, 0);
        idle(2);

        // Both strobes high: write wins, read_data untouched. 1048 -> halves 12/13.
        access(1, 1, 32'd1048, 32'hA5A5_5A5A, 18'd12, 32'hDEAD_BEEF, 1, 0);
        idle(2);
        check("both_high_read_data_kept", read_data, 32'hDEAD_BEEF);

        // Back-to-back loads: second request held through DONE.
        access(0, 1, 32'd1032, 32'h0, 18'd0, 32'hDEAD_BEEF, 0, 0);
        access(0, 1, 32'd1048, 32'h0, 18'd0, 32'hA5A5_5A5A, 1, 0);
        idle(2);

        // Reset on the last low-half cycle of a store to 1040 (halves 8/9).
        sb.push_back('{is_done: 1'b0, addr: 18'd8, data: 32'h0000_5678});
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'h1234_5678;
        idle(5);
        rst   = 1'b1;
        wr_en = 1'b0;
        tick();
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_read_data", read_data, 32'd0);
        idle(2);
        access(0, 1, 32'd1040, 32'h0, 18'd0, 32'h0000_5678, 1, 0);
        idle(2);

        // Wrap: 1024 + 4*2^17 lands on halves 0/1; mid-access input changes ignored.
        access(1, 0, 32'd525312, 32'hCAFE_F00D, 18'd0, 32'h0000_5678, 1, 2);
        idle(2);
        access(0, 1, 32'd1024, 32'h0, 18'd0, 32'hCAFE_F00D, 1, 3);
        idle(3);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sram_ctrl
`default_nettype wire
